// File: rtl/ldst_controller_if.sv
// Bundle of the lw/sw sequencer's request, register-file, ALU and data-memory signals.
// The master side is the controller; the slave side is everything it talks to.
interface ldst_controller_if;
    logic        start;
    logic [31:0] instruction;
    logic        busy;
    logic        done;
    logic        error;

    logic [4:0]  rf_read_reg1;
    logic [4:0]  rf_read_reg2;
    logic [31:0] rf_read_data1;
    logic [31:0] rf_read_data2;
    logic [4:0]  rf_write_reg;
    logic [31:0] rf_write_data;
    logic        rf_reg_write;

    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_control;
    logic [31:0] alu_result;

    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_read;
    logic        mem_write;
    logic        mem_ready;
    logic [31:0] mem_read_data;

    modport master (
        input  start, instruction, rf_read_data1, rf_read_data2, alu_result,
               mem_ready, mem_read_data,
        output busy, done, error, rf_read_reg1, rf_read_reg2, rf_write_reg,
               rf_write_data, rf_reg_write, alu_a, alu_b, alu_control,
               mem_address, mem_write_data, mem_read, mem_write
    );

    modport slave (
        output start, instruction, rf_read_data1, rf_read_data2, alu_result,
               mem_ready, mem_read_data,
        input  busy, done, error, rf_read_reg1, rf_read_reg2, rf_write_reg,
               rf_write_data, rf_reg_write, alu_a, alu_b, alu_control,
               mem_address, mem_write_data, mem_read, mem_write
    );
endinterface

// File: rtl/ldst_controller.sv
// Multi-cycle lw/sw sequencer: decode, address add on the shared ALU, handshaked
// memory access with timeout, and register writeback for loads.
module ldst_controller #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               reset,
    ldst_controller_if.master  bus
);
    localparam logic [5:0] OP_LW = 6'h23;
    localparam logic [5:0] OP_SW = 6'h2B;
    localparam int unsigned CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_DECODE, S_ADDR, S_MEM, S_WB, S_DONE
    } state_t;

    state_t        state_q;
    logic [31:0]   instr_q;
    logic [31:0]   base_q;
    logic [31:0]   store_q;
    logic [31:0]   addr_q;
    logic [31:0]   load_q;
    logic [CW-1:0] wait_q;
    logic          err_q;
    logic          busy_q;
    logic          done_q;
    logic          error_q;
    logic          mem_read_q;
    logic          mem_write_q;
    logic          rf_reg_write_q;
    logic [2:0]    alu_control_q;

    logic is_lw;
    logic legal_op;
    assign is_lw    = (instr_q[31:26] == OP_LW);
    assign legal_op = is_lw || (instr_q[31:26] == OP_SW);

    // Data outputs are straight from holding registers; only the strobes are gated by state.
    assign bus.rf_read_reg1   = instr_q[25:21];
    assign bus.rf_read_reg2   = instr_q[20:16];
    assign bus.rf_write_reg   = instr_q[20:16];
    assign bus.rf_write_data  = load_q;
    assign bus.alu_a          = base_q;
    assign bus.alu_b          = {{16{instr_q[15]}}, instr_q[15:0]};
    assign bus.alu_control    = alu_control_q;
    assign bus.mem_address    = addr_q;
    assign bus.mem_write_data = store_q;
    assign bus.mem_read       = mem_read_q;
    assign bus.mem_write      = mem_write_q;
    assign bus.rf_reg_write   = rf_reg_write_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.error          = error_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            instr_q        <= '0;
            base_q         <= '0;
            store_q        <= '0;
            addr_q         <= '0;
            load_q         <= '0;
            wait_q         <= '0;
            err_q          <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
            mem_read_q     <= 1'b0;
            mem_write_q    <= 1'b0;
            rf_reg_write_q <= 1'b0;
            alu_control_q  <= 3'b000;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        instr_q <= bus.instruction;
                        busy_q  <= 1'b1;
                        state_q <= S_DECODE;
                    end
                end

                S_DECODE: begin
                    if (legal_op) begin
                        base_q        <= bus.rf_read_data1;
                        store_q       <= bus.rf_read_data2;
                        alu_control_q <= 3'b010;
                        state_q       <= S_ADDR;
                    end else begin
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        error_q <= 1'b1;
                        state_q <= S_DONE;
                    end
                end

                S_ADDR: begin
                    addr_q        <= bus.alu_result;
                    alu_control_q <= 3'b000;
                    wait_q        <= '0;
                    if (bus.alu_result[1:0] != 2'b00) begin
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        error_q <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        mem_read_q  <= is_lw;
                        mem_write_q <= !is_lw;
                        state_q     <= S_MEM;
                    end
                end

                S_MEM: begin
                    // A ready on the final permitted cycle still completes the access.
                    if (bus.mem_ready) begin
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        if (is_lw) begin
                            load_q         <= bus.mem_read_data;
                            rf_reg_write_q <= (instr_q[20:16] != 5'd0);
                            state_q        <= S_WB;
                        end else begin
                            done_q  <= 1'b1;
                            error_q <= err_q;
                            state_q <= S_DONE;
                        end
                    end else if (wait_q == WAIT_LAST) begin
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        err_q       <= 1'b1;
                        done_q      <= 1'b1;
                        error_q     <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end

                S_WB: begin
                    rf_reg_write_q <= 1'b0;
                    done_q         <= 1'b1;
                    error_q        <= err_q;
                    state_q        <= S_DONE;
                end

                S_DONE: begin
                    done_q  <= 1'b0;
                    error_q <= 1'b0;
                    err_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ldst_controller.sv
// Randomized scoreboard bench for ldst_controller with register-file, ALU and memory models.
module tb_ldst_controller;
    localparam int T = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    ldst_controller_if bus();
    ldst_controller #(.MEM_TIMEOUT(T)) dut (.clk(clk), .reset(reset), .bus(bus.master));

    typedef struct {
        int          start_cyc;
        int          lat;
        bit          err;
        int          strobes;
        bit          is_lw;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          rfw;
        logic [4:0]  wreg;
        logic [31:0] wval;
    } exp_t;

    exp_t        q[$];
    logic [31:0] rf [32];
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    int          cur_wait = 0;
    int          scnt = 0;
    bit          stray = 1'b0;
    int          done_total = 0;
    int          rfw_total = 0;

    // Environment models: combinational register file and ALU, memory with programmable wait.
    assign bus.rf_read_data1 = rf[bus.rf_read_reg1];
    assign bus.rf_read_data2 = rf[bus.rf_read_reg2];
    assign bus.alu_result = (bus.alu_control == 3'b010) ? bus.alu_a + bus.alu_b
                                                        : (bus.alu_a & bus.alu_b);
    assign bus.mem_ready = (bus.mem_read || bus.mem_write) ? (scnt == cur_wait) : stray;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.mem_read || bus.mem_write) scnt <= scnt + 1;
        else scnt <= 0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic exp_t model(input logic [31:0] instr, input int w, input logic [31:0] rdata);
        exp_t e;
        logic [5:0]  op = instr[31:26];
        logic [4:0]  rs = instr[25:21];
        logic [4:0]  rt = instr[20:16];
        logic [31:0] off = {{16{instr[15]}}, instr[15:0]};
        e = '{default: 0};
        e.is_lw = (op == 6'h23);
        e.addr  = rf[rs] + off;
        e.wdata = rf[rt];
        e.wreg  = rt;
        e.wval  = rdata;
        if (op != 6'h23 && op != 6'h2B) begin
            e.err = 1; e.lat = 2;
        end else if (e.addr[1:0] != 2'b00) begin
            e.err = 1; e.lat = 3;
        end else if (w >= T) begin
            e.err = 1; e.lat = 3 + T; e.strobes = T;
        end else begin
            e.strobes = w + 1;
            e.lat = e.is_lw ? 5 + w : 4 + w;
            e.rfw = (e.is_lw && rt != 5'd0) ? 1 : 0;
        end
        return e;
    endfunction

    // Monitor: accumulates what the DUT does per operation and scores it on done.
    int          m_strobes = 0, m_both = 0, m_rfw = 0;
    bit          m_rd = 0, m_wr = 0;
    logic [31:0] m_addr = '0, m_wdata = '0, m_wval = '0;
    logic [4:0]  m_wreg = '0;

    always @(negedge clk) begin
        if (!reset) begin
            m_strobes = 0; m_both = 0; m_rfw = 0; m_rd = 0; m_wr = 0;
        end else begin
            if (bus.mem_read && bus.mem_write) m_both++;
            if (bus.mem_read || bus.mem_write) begin
                m_strobes++;
                m_rd    = m_rd | bus.mem_read;
                m_wr    = m_wr | bus.mem_write;
                m_addr  = bus.mem_address;
                m_wdata = bus.mem_write_data;
            end
            if (bus.rf_reg_write) begin
                m_rfw++; rfw_total++;
                m_wreg = bus.rf_write_reg;
                m_wval = bus.rf_write_data;
            end
            if (bus.done) begin
                exp_t e;
                done_total++;
                if (q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("latency", cyc - e.start_cyc, e.lat);
                    chk("error", bus.error, e.err);
                    chk("strobe_cycles", m_strobes, e.strobes);
                    chk("strobe_both", m_both, 0);
                    if (e.strobes > 0) begin
                        chk("mem_address", m_addr, e.addr);
                        chk("mem_read_seen", m_rd, e.is_lw);
                        chk("mem_write_seen", m_wr, !e.is_lw);
                        if (!e.is_lw) chk("mem_write_data", m_wdata, e.wdata);
                    end
                    chk("rf_write_count", m_rfw, e.rfw);
                    if (e.rfw > 0) begin
                        chk("rf_write_reg", m_wreg, e.wreg);
                        chk("rf_write_data", m_wval, e.wval);
                    end
                end
                m_strobes = 0; m_both = 0; m_rfw = 0; m_rd = 0; m_wr = 0;
            end
        end
    end

    // Issue one instruction (entered at posedge+1 of an IDLE cycle) and wait for done.
    task automatic run_op(input logic [31:0] instr, input int w, input logic [31:0] rdata);
        exp_t e;
        bit   seen = 0;
        cur_wait = w;
        bus.mem_read_data = rdata;
        e = model(instr, w, rdata);
        e.start_cyc = cyc;
        q.push_back(e);
        bus.start = 1'b1;
        bus.instruction = instr;
        for (int n = 0; n < 60; n++) begin
            @(posedge clk); #1;
            stray = 1'($urandom);
            if (bus.done) begin
                bus.start = 1'b0;
                seen = 1;
                break;
            end
            chk("busy_active", bus.busy, 1'b1);
            bus.start = 1'($urandom);
            bus.instruction = $urandom;
        end
        if (!seen) chk("done_timeout", 32'd0, 32'd1);
        bus.start = 1'b0;
        @(posedge clk); #1;
        chk("busy_idle", bus.busy, 1'b0);
    endtask

    initial begin
        int snap_done, snap_rfw;
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        rf[0] = '0;
        bus.start = 1'b0;
        bus.instruction = '0;
        bus.mem_read_data = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_error", bus.error, 0);
        chk("rst_strobes", {bus.mem_read, bus.mem_write, bus.rf_reg_write}, 0);
        chk("rst_alu_control", bus.alu_control, 0);
        chk("rst_mem_address", bus.mem_address, 0);
        reset = 1'b1;
        @(posedge clk); #1;

        rf[8] = 32'h0000_1000;
        rf[9] = 32'hDEAD_BEEF;
        run_op(32'hAD09FFFC, 0, 32'h0);
        run_op(32'h8D0A0008, 3, 32'h1234_5678);
        run_op(32'h8D0A0002, 0, 32'h0);
        run_op(32'h0000_0020, 0, 32'h0);
        run_op(32'hAD09FFFC, 99, 32'h0);

        // Abort a load stalled in MEM by asserting reset between clock edges.
        cur_wait = 99;
        bus.start = 1'b1;
        bus.instruction = 32'h8D0A0008;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int n = 0; n < 20 && !bus.mem_read; n++) begin
            @(posedge clk); #1;
        end
        chk("abort_in_mem", bus.mem_read, 1'b1);
        @(posedge clk); #3;
        snap_done = done_total;
        snap_rfw  = rfw_total;
        reset = 1'b0;
        #1;
        chk("abort_mem_read", bus.mem_read, 0);
        chk("abort_busy", bus.busy, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("abort_no_done", done_total, snap_done);
        chk("abort_no_rf_write", rfw_total, snap_rfw);
        run_op(32'h8D0A0008, 1, 32'hCAFE_F00D);

        for (int k = 0; k < 150; k++) begin
            logic [4:0]  rs = 5'($urandom);
            logic [4:0]  rt = 5'($urandom);
            logic [15:0] off = 16'($urandom);
            logic [5:0]  op;
            int          sel = $urandom_range(0, 9);
            if (rs != 0) rf[rs] = $urandom;
            if (rt != 0 && rt != rs) rf[rt] = $urandom;
            op = (sel < 4) ? 6'h23 : (sel < 8) ? 6'h2B : 6'($urandom);
            if ($urandom_range(0, 3) != 0) off[1:0] = 2'(3'd4 - {1'b0, rf[rs][1:0]});
            run_op({op, rs, rt, off}, $urandom_range(0, T + 2), $urandom);
        end

        repeat (5) @(posedge clk);
        chk("scoreboard_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
